uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
// - UART byte receiver; consumes the serial line driven by the team's UART byte transmitter.
// - Frame format: 8N1, LSB first, line idles high. Default rate 9600 baud at 50 MHz.
// - Synchronises the asynchronous line, checks the start bit at mid-bit and samples each data bit at mid-bit.
// - Presents each received byte with a 1-cycle done strobe to downstream logic (LED/display/loopback).
// PARAMETERS
// - BAUD_COUNTER_MAX   5207  Clocks per bit minus 1 (50e6/9600 - 1).
// - SAMPLE_POINT       2603  Baud-counter value at which the line is sampled (BAUD_COUNTER_MAX/2).
// - STATE_COUNTER_MAX  7     Index of the last data bit.
// PORTS
// - i_sysclk     in   1  System clock, 50 MHz.
// - i_rst_n      in   1  Reset, synchronous, active-low. Sampled on the i_sysclk rising edge.
// - i_uart_rx    in   1  Asynchronous serial input. Idles high.
// - o_data       out  8  Last good byte. Updated only on a good frame.
// - o_rx_done    out  1  1-cycle pulse: o_data holds a new byte.
// - o_frame_err  out  1  1-cycle pulse: the stop bit was sampled low.
// - o_busy       out  1  High from start-edge detection until the state machine returns to IDLE.
// - o_led        out  1  Present only with UART_RX_LED_EN; see CONFIGURATION.
// BEHAVIOUR
// - Reset (i_rst_n=0 at a clock edge):
//   - State = IDLE; counters = 0; synchroniser FFs = 1.
//   - o_data=8'h00, o_rx_done=0, o_frame_err=0, o_busy=0, o_led=0.
//   - Reset mid-frame aborts the frame; no strobe is issued.
// - Input path: 2-FF synchroniser (rx_s2), plus a third FF (rx_s3) for edge detection.
//   - Start edge = rx_s3 & ~rx_s2.
// - Baud counter: 13 bits, 0..BAUD_COUNTER_MAX, wraps to 0.
//   - Counts only outside IDLE. Cleared on entry to START.
// - State machine:
//   - IDLE:  on a start edge -> START, o_busy=1.
//   - START: at count==SAMPLE_POINT:
//     - rx_s2=1 -> IDLE (false start; no strobe; o_busy=0).
//     - rx_s2=0 -> DATA, bit index = 0.
//   - DATA:  at each count==SAMPLE_POINT, shift rx_s2 into bit[index]; index 0..7.
//     - Index 7 sampled -> STOP.
//   - STOP:  at count==SAMPLE_POINT:
//     - rx_s2=1 -> o_data <= shift reg, o_rx_done=1 for one cycle.
//     - rx_s2=0 -> o_frame_err=1 for one cycle; o_data holds.
//     - Either way -> IDLE, o_busy=0, same cycle as the strobe.
// - Return at mid-stop-bit lets back-to-back frames with zero idle time be received.
// - Start-edge detection is ignored outside IDLE.
// - Latency: the strobe rises 1 clock after the stop-bit sample point.
//   - This is about 9.5 bit periods (~49474 clocks) after the falling start edge, plus 2-3 clocks of synchroniser delay.
// - o_rx_done and o_frame_err are never high together.
// CONFIGURATION
// - UART_RX_LED_EN defined:
//   - o_led port exists and toggles on every o_rx_done pulse.
//   - o_led does not toggle on o_frame_err or on a false start.
// - UART_RX_LED_EN undefined: o_led port and its logic are absent; all other behaviour is identical.
// TESTING
// - Drive 0x55 at 9600 8N1 -> one o_rx_done pulse ~49480 clocks after the start edge; o_data=8'h55; o_frame_err=0.
// - Low glitch on i_uart_rx for 1000 clocks, then high -> o_busy high then back to 0 at the sample point; no strobe; o_data unchanged.
// - Frame 0xA5 with stop bit forced 0 -> o_frame_err pulse for exactly 1 clock; o_rx_done stays 0; o_data keeps its previous value.
// - Back-to-back 0xA5 then 0x3C, no idle bits -> two o_rx_done pulses 10 bit periods (52080 clocks) apart; o_data=8'hA5, then 8'h3C.
// - Assert i_rst_n=0 for 1 clock during data bit 4 of 0xFF -> all outputs reset; no strobe; the next clean 0x0F is received correctly.
// - With UART_RX_LED_EN: 3 good frames plus 1 bad frame -> o_led toggles 3 times (ends at 1).

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//
// Receives 8N1 UART frames (LSB first, line idles high) from the UART byte
// transmitter. The default parameters give 9600 baud from a 50 MHz clock.
// The serial line goes through a two-flop synchroniser, and a third flop is
// used for edge detection. The receiver checks the start bit at mid-bit and
// samples each data bit at mid-bit. It sets o_data only when a frame is good
// and reports the result with a one-cycle strobe.
//
// Ports
//   i_sysclk     in   1  system clock
//   i_rst_n      in   1  synchronous active-low reset
//   i_uart_rx    in   1  asynchronous serial input, idles high
//   o_data       out  8  last good byte
//   o_rx_done    out  1  one-cycle pulse, o_data holds a new byte
//   o_frame_err  out  1  one-cycle pulse, the stop bit was sampled low
//   o_busy       out  1  high from the start edge until the FSM is back in IDLE
//   o_led        out  1  exists only when UART_RX_LED_EN is defined; toggles
//                        on every o_rx_done pulse
//
// Build option: define UART_RX_LED_EN to add the o_led port and its toggle.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a falling edge on the synchronised line
// START  | checking the start bit at its midpoint (a high level = false start)
// DATA   | sampling data bits 0..STATE_COUNTER_MAX at their midpoints
// STOP   | sampling the stop bit, then strobing done or frame error

module uart_byte_rx #(
  parameter logic [12:0] BAUD_COUNTER_MAX  = 13'd5207,
  parameter logic [12:0] SAMPLE_POINT      = 13'd2603,
  parameter logic [2:0]  STATE_COUNTER_MAX = 3'd7
) (
  input  logic       i_sysclk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_busy
`ifdef UART_RX_LED_EN
  ,
  output logic       o_led
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic [1:0]  state_q, state_d;
  logic [12:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
`ifdef UART_RX_LED_EN
  logic        led_q, led_d;
`endif

  logic start_edge;
  logic sample_hit;

  assign start_edge = rx_s3_q & ~rx_s2_q;
  assign sample_hit = (baud_cnt_q == SAMPLE_POINT);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    busy_d     = busy_q;
`ifdef UART_RX_LED_EN
    led_d      = led_q;
`endif

    // The counter runs freely through the whole frame. The START decision is
    // taken at SAMPLE_POINT, so every later SAMPLE_POINT hit falls in the
    // middle of the next bit.
    if (state_q != ST_IDLE) begin
      if (baud_cnt_q == BAUD_COUNTER_MAX) begin
        baud_cnt_d = 13'd0;
      end else begin
        baud_cnt_d = baud_cnt_q + 13'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = 13'd0;
        if (start_edge) begin
          state_d = ST_START;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (sample_hit) begin
          if (rx_s2_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end

      ST_DATA: begin
        if (sample_hit) begin
          shift_d[bit_idx_q] = rx_s2_q;
          if (bit_idx_q == STATE_COUNTER_MAX) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      ST_STOP: begin
        // Returning at mid-stop-bit leaves half a bit to catch the start
        // edge of a frame that follows with no idle time.
        if (sample_hit) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (rx_s2_q) begin
            data_d = shift_q;
            done_d = 1'b1;
`ifdef UART_RX_LED_EN
            led_d  = ~led_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      state_q    <= ST_IDLE;
      baud_cnt_q <= 13'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_LED_EN
      led_q      <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= i_uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef UART_RX_LED_EN
      led_q      <= led_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;
`ifdef UART_RX_LED_EN
  assign o_led       = led_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx. The bit period is shortened to 16 clocks
// so that the run stays short.
module tb_uart_byte_rx;

  localparam logic [12:0] BMAX     = 13'd15;
  localparam logic [12:0] SP       = 13'd7;
  localparam int          BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done, o_frame_err, o_busy;
`ifdef UART_RX_LED_EN
  logic       o_led;
  logic       led_exp = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_byte_rx #(
    .BAUD_COUNTER_MAX (BMAX),
    .SAMPLE_POINT     (SP),
    .STATE_COUNTER_MAX(3'd7)
  ) dut (
    .i_sysclk   (clk),
    .i_rst_n    (rst_n),
    .i_uart_rx  (rx),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
`ifdef UART_RX_LED_EN
    ,
    .o_led      (o_led)
`endif
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_last = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A good stop bit gives a done strobe carrying the byte. A low stop bit
  // gives a frame error, and o_data keeps the last good byte. If reset is
  // injected during the frame, nothing is expected from that frame and the
  // last good byte returns to zero.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
    logic [9:0] fr;
    exp_t e;
    fr = {stop, b, 1'b0};
    if (rst_bit < 0) begin
      e.is_err = !stop;
      if (stop) model_last = b;
      e.data = model_last;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == rst_bit) begin
        tick(8);
        rst_n = 1'b0;
        model_last = 8'h00;
        tick(1);
        check("rst_data", o_data, 8'h00);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_rx_done, 0);
        check("rst_ferr", o_frame_err, 0);
        rst_n = 1'b1;
        tick(BIT_CLKS - 9);
      end else begin
        tick(BIT_CLKS);
      end
    end
    rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (o_rx_done || o_frame_err) begin
      check("exclusive_strobes", {31'd0, o_rx_done & o_frame_err}, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got done=%0b err=%0b expected none", o_rx_done, o_frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind_err", o_frame_err, mon_e.is_err);
        check("strobe_kind_done", o_rx_done, !mon_e.is_err);
        check("data", o_data, mon_e.data);
`ifdef UART_RX_LED_EN
        if (!mon_e.is_err) led_exp = ~led_exp;
        check("led", o_led, led_exp);
`endif
      end
    end
  end

  initial begin
    tick(60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] b;
    logic st;
    tick(3);
    check("reset_data", o_data, 8'h00);
    check("reset_done", o_rx_done, 0);
    check("reset_ferr", o_frame_err, 0);
    check("reset_busy", o_busy, 0);
`ifdef UART_RX_LED_EN
    check("reset_led", o_led, 0);
`endif
    rst_n = 1'b1;
    tick(5);

    send_frame(8'h55, 1'b1, -1);
    tick(20);
    check("idle_busy", o_busy, 0);

    // A short low glitch must start the receiver and then abort it.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    k = 0;
    while (!o_busy && k < 20) begin tick(1); k++; end
    check("glitch_busy_rise", o_busy, 1);
    k = 0;
    while (o_busy && k < 40) begin tick(1); k++; end
    check("glitch_busy_fall", o_busy, 0);
    check("glitch_data_hold", o_data, model_last);
    tick(20);

    send_frame(8'hA5, 1'b0, -1);
    tick(BIT_CLKS + 4);
    send_frame(8'hA5, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    tick(10);
    send_frame(8'hFF, 1'b1, 5);
    tick(10);
    check("post_reset_data", o_data, 8'h00);
    send_frame(8'h0F, 1'b1, -1);
    tick(10);

    for (int n = 0; n < 25; n++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(b, st, -1);
      if (st) tick($urandom_range(0, 20));
      else    tick($urandom_range(BIT_CLKS, 2 * BIT_CLKS));
    end

    tick(40);
    check("queue_empty", exp_q.size(), 0);
    check("final_busy", o_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
